// File: rtl/nv_minmax_pkg.sv
// Shared types and width helpers for the min/max frame reducer.
// Contents: FSM state enum, ceil-log2 helper clamped to a minimum of 1,
// and the derived global-index / lane-index width functions.
package nv_minmax_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // ceil(log2(n)), never less than 1 so zero-width vectors cannot occur
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned idx_width(input int unsigned lanes,
                                            input int unsigned beats);
    return clog2_min1(lanes * beats);
  endfunction

  function automatic int unsigned lane_width(input int unsigned lanes);
    return clog2_min1(lanes);
  endfunction

endpackage

// File: rtl/nv_minmax_lane_tree.sv
// Combinational reduction of one beat's lanes to a single winner.
// Ports: data (NUM_INPUTS lanes of WIDTH bits, lane k at [k*WIDTH +: WIDTH]),
//        mode_max (1 = max, 0 = min), cmp_signed (only with NV_MINMAX_TC_EN),
//        win_value / win_lane (winning value and its lane index).
// Ties resolve to the lowest lane because replacement needs a strict compare.
// Build option: NV_MINMAX_TC_EN adds two's-complement comparison.
module nv_minmax_lane_tree
  import nv_minmax_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned LANE_W     = 2
) (
  input  logic [NUM_INPUTS*WIDTH-1:0] data,
  input  logic                        mode_max,
`ifdef NV_MINMAX_TC_EN
  input  logic                        cmp_signed,
`endif
  output logic [WIDTH-1:0]            win_value,
  output logic [LANE_W-1:0]           win_lane
);

`ifdef NV_MINMAX_TC_EN
  // Flipping the MSB maps two's-complement order onto unsigned order
  function automatic logic better(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic mx, input logic sg);
    logic [WIDTH-1:0] ka, kb;
    ka = a;
    kb = b;
    ka[WIDTH-1] = a[WIDTH-1] ^ sg;
    kb[WIDTH-1] = b[WIDTH-1] ^ sg;
    return mx ? (ka > kb) : (ka < kb);
  endfunction
`else
  function automatic logic better(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic mx);
    return mx ? (a > b) : (a < b);
  endfunction
`endif

  // Linear scan: a later lane replaces the winner only if strictly better
  always_comb begin
    win_value = data[WIDTH-1:0];
    win_lane  = '0;
    for (int unsigned k = 1; k < NUM_INPUTS; k++) begin
`ifdef NV_MINMAX_TC_EN
      if (better(data[k*WIDTH +: WIDTH], win_value, mode_max, cmp_signed)) begin
`else
      if (better(data[k*WIDTH +: WIDTH], win_value, mode_max)) begin
`endif
        win_value = data[k*WIDTH +: WIDTH];
        win_lane  = LANE_W'(k);
      end
    end
  end

endmodule

// File: rtl/nv_minmax_reduce.sv
// Frame-level min/max reducer with global winner index and overflow flag.
// Ports: nvdla_core_clk / nvdla_core_rstn (async active-low reset);
//        in_valid/in_ready/in_data/in_last beat stream, min_max and tc
//        sampled on the first beat; out_valid/out_ready result handshake
//        with out_value, out_index (beat*NUM_INPUTS + lane) and out_ovf.
// Build option: NV_MINMAX_TC_EN honours tc (signed compare); otherwise tc
// is ignored and only unsigned comparison exists.
module nv_minmax_reduce
  import nv_minmax_pkg::*;
#(
  parameter  int unsigned WIDTH      = 8,
  parameter  int unsigned NUM_INPUTS = 4,
  parameter  int unsigned MAX_BEATS  = 16,
  localparam int unsigned IDX_W      = idx_width(NUM_INPUTS, MAX_BEATS)
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  input  logic                        in_last,
  input  logic                        min_max,
  input  logic                        tc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_value,
  output logic [IDX_W-1:0]            out_index,
  output logic                        out_ovf
);

  localparam int unsigned LANE_W = lane_width(NUM_INPUTS);
  localparam int unsigned BEAT_W = clog2_min1(MAX_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

  state_e             state_q, state_d;
  logic               accept, first, take;
  logic               mode_max_q, cur_max;
  logic [BEAT_W-1:0]  cnt_q, cur_beat;
  logic               full_q, cur_full;
  logic [WIDTH-1:0]   win_value, acc_value_q;
  logic [LANE_W-1:0]  win_lane;
  logic [IDX_W-1:0]   acc_index_q, cur_index;
  logic               ovf_q;

  assign in_ready  = (state_q != ST_DONE);
  assign out_valid = (state_q == ST_DONE);
  assign out_value = acc_value_q;
  assign out_index = acc_index_q;
  assign out_ovf   = ovf_q;

  assign accept   = in_valid & in_ready;
  assign first    = (state_q == ST_IDLE);
  // First beat uses live mode pins; later beats use the latched copy
  assign cur_max  = first ? min_max : mode_max_q;
  assign cur_beat = first ? '0 : cnt_q;
  // full_q: the last counted beat slot has been used, so this beat overflows
  assign cur_full = first ? 1'b0 : full_q;
  assign cur_index = IDX_W'(cur_beat) * IDX_W'(NUM_INPUTS) + IDX_W'(win_lane);

`ifdef NV_MINMAX_TC_EN
  logic mode_tc_q, cur_tc;
  assign cur_tc = first ? tc : mode_tc_q;

  // Same MSB-flip trick as the lane tree for the accumulator compare
  function automatic logic better(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic mx, input logic sg);
    logic [WIDTH-1:0] ka, kb;
    ka = a;
    kb = b;
    ka[WIDTH-1] = a[WIDTH-1] ^ sg;
    kb[WIDTH-1] = b[WIDTH-1] ^ sg;
    return mx ? (ka > kb) : (ka < kb);
  endfunction

  assign take = first | better(win_value, acc_value_q, cur_max, cur_tc);
`else
  logic unused_tc;
  assign unused_tc = tc;

  function automatic logic better(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic mx);
    return mx ? (a > b) : (a < b);
  endfunction

  assign take = first | better(win_value, acc_value_q, cur_max);
`endif

  nv_minmax_lane_tree #(
    .WIDTH      (WIDTH),
    .NUM_INPUTS (NUM_INPUTS),
    .LANE_W     (LANE_W)
  ) u_lane_tree (
    .data       (in_data),
    .mode_max   (cur_max),
`ifdef NV_MINMAX_TC_EN
    .cmp_signed (cur_tc),
`endif
    .win_value  (win_value),
    .win_lane   (win_lane)
  );

  // State register
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) state_q <= ST_IDLE;
    else                  state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_ACC: if (accept) state_d = in_last ? ST_DONE : ST_ACC;
      ST_DONE:         if (out_ready) state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // Accumulator, beat counter and mode latches; frozen outside accepted beats
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      mode_max_q  <= 1'b0;
`ifdef NV_MINMAX_TC_EN
      mode_tc_q   <= 1'b0;
`endif
      cnt_q       <= '0;
      full_q      <= 1'b0;
      acc_value_q <= '0;
      acc_index_q <= '0;
      ovf_q       <= 1'b0;
    end else if (accept) begin
      if (first) begin
        mode_max_q <= min_max;
`ifdef NV_MINMAX_TC_EN
        mode_tc_q  <= tc;
`endif
      end
      if (take) begin
        acc_value_q <= win_value;
        acc_index_q <= cur_index;
      end
      ovf_q  <= cur_full;
      cnt_q  <= (cur_beat == LAST_BEAT) ? cur_beat : cur_beat + BEAT_W'(1);
      full_q <= cur_full | (cur_beat == LAST_BEAT);
    end
  end

endmodule

// File: tb/tb_nv_minmax_reduce.sv
// Directed bench for nv_minmax_reduce (WIDTH=8, NUM_INPUTS=4, MAX_BEATS=4).
module tb_nv_minmax_reduce;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned NUM_INPUTS = 4;
  localparam int unsigned MAX_BEATS  = 4;
  localparam int unsigned IDX_W      = 4;

  logic                        clk;
  logic                        rst_n;
  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_INPUTS*WIDTH-1:0] in_data;
  logic                        in_last;
  logic                        min_max;
  logic                        tc;
  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH-1:0]            out_value;
  logic [IDX_W-1:0]            out_index;
  logic                        out_ovf;

  int checks;
  int failures;

  nv_minmax_reduce #(
    .WIDTH      (WIDTH),
    .NUM_INPUTS (NUM_INPUTS),
    .MAX_BEATS  (MAX_BEATS)
  ) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_last         (in_last),
    .min_max         (min_max),
    .tc              (tc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_value       (out_value),
    .out_index       (out_index),
    .out_ovf         (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat at a negedge; returns #1 after the accepting posedge
  task automatic send_beat(input logic [31:0] d, input logic last,
                           input logic mm, input logic t);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    min_max  = mm;
    tc       = t;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("beat_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the last beat: result must already be valid
  task automatic expect_frame(input string tag, input logic [7:0] v,
                              input logic [3:0] idx, input logic ovf);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_value"}, 32'(out_value), 32'(v));
    check({tag, "_index"}, 32'(out_index), 32'(idx));
    check({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
    check({tag, "_ready"},   32'(in_ready),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    min_max   = 1'b0;
    tc        = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_value", 32'(out_value), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    rst_n = 1'b1;

    // Max unsigned, tie on 9 resolves to the earliest index
    send_beat({8'h01, 8'h09, 8'h09, 8'h03}, 1'b0, 1'b1, 1'b0);
    check("acc_not_valid", 32'(out_valid), 32'd0);
    send_beat({8'h00, 8'h00, 8'h09, 8'h02}, 1'b1, 1'b1, 1'b0);
    expect_frame("max2", 8'h09, 4'd1, 1'b0);

    // Single-beat min with tc requested
    send_beat({8'h7F, 8'h80, 8'hF0, 8'h05}, 1'b1, 1'b0, 1'b1);
`ifdef NV_MINMAX_TC_EN
    expect_frame("min_tc", 8'h80, 4'd2, 1'b0);
`else
    expect_frame("min_tc", 8'h05, 4'd0, 1'b0);
`endif

    // Same vector with tc=0 is always unsigned
    send_beat({8'h7F, 8'h80, 8'hF0, 8'h05}, 1'b1, 1'b1, 1'b0);
    expect_frame("max_uns", 8'hF0, 4'd1, 1'b0);

    // Min with ties across beats: first 3 wins
    send_beat({8'h09, 8'h03, 8'h03, 8'h07}, 1'b0, 1'b0, 1'b0);
    send_beat({8'h08, 8'h08, 8'h08, 8'h03}, 1'b1, 1'b0, 1'b0);
    expect_frame("min_tie", 8'h03, 4'd1, 1'b0);

    // Backpressure: result held, new beats refused
    send_beat({8'h04, 8'h03, 8'h02, 8'h01}, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = 32'hFFFF_FFFF;
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_value", 32'(out_value), 32'h04);
      check("bp_out_index", 32'(out_index), 32'd3);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    expect_frame("bp", 8'h04, 4'd3, 1'b0);

    // Exactly MAX_BEATS beats: no overflow, winner in last slot
    send_beat({8'h01, 8'h01, 8'h01, 8'h01}, 1'b0, 1'b1, 1'b0);
    send_beat({8'h01, 8'h01, 8'h01, 8'h01}, 1'b0, 1'b1, 1'b0);
    send_beat({8'h01, 8'h01, 8'h01, 8'h01}, 1'b0, 1'b1, 1'b0);
    send_beat({8'h02, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b1, 1'b0);
    expect_frame("four_beats", 8'h02, 4'd15, 1'b0);

    // Five beats: overflow, index uses saturated beat number
    send_beat({8'h04, 8'h03, 8'h02, 8'h01}, 1'b0, 1'b1, 1'b0);
    send_beat({8'h10, 8'h20, 8'h30, 8'h40}, 1'b0, 1'b1, 1'b0);
    send_beat({8'h11, 8'h22, 8'h33, 8'h44}, 1'b0, 1'b1, 1'b0);
    send_beat({8'h05, 8'h06, 8'h07, 8'h08}, 1'b0, 1'b1, 1'b0);
    send_beat({8'hEE, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b1, 1'b0);
    expect_frame("ovf", 8'hEE, 4'd15, 1'b1);

    // Overflow flag clears on the next frame
    send_beat({8'h00, 8'h00, 8'h00, 8'h33}, 1'b1, 1'b1, 1'b0);
    expect_frame("ovf_clear", 8'h33, 4'd0, 1'b0);

    // min_max toggled mid-frame is ignored: still frame minimum
    send_beat({8'd70, 8'd60, 8'd40, 8'd50}, 1'b0, 1'b0, 1'b0);
    send_beat({8'd30, 8'd20, 8'd90, 8'd10}, 1'b0, 1'b1, 1'b0);
    send_beat({8'd5,  8'd99, 8'd10, 8'd80}, 1'b1, 1'b1, 1'b0);
    expect_frame("mode_latch", 8'd5, 4'd11, 1'b0);

    // Reset mid-frame discards partial result
    send_beat({8'h01, 8'h01, 8'h01, 8'h01}, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_out_value", 32'(out_value), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 32'(out_valid), 32'd0);
    send_beat({8'h07, 8'h07, 8'h07, 8'h07}, 1'b1, 1'b1, 1'b0);
    expect_frame("post_rst", 8'h07, 4'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nv_minmax_reduce.md
NV_MINMAX_REDUCE -- requirements
Module: nv_minmax_reduce

Interface
REQ-001 Parameter WIDTH, default 8, element width in bits.
REQ-002 Parameter NUM_INPUTS, default 4, lanes per beat (1..64).
REQ-003 Parameter MAX_BEATS, default 16, beats per frame before overflow (>=1).
REQ-004 Derived IDX_W = max(1, clog2(NUM_INPUTS*MAX_BEATS)), global index width.
REQ-005 nvdla_core_clk  in  1  sole clock, rising edge.
REQ-006 nvdla_core_rstn  in  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  in  1  beat valid.
REQ-008 in_ready  out  1  beat accepted when in_valid & in_ready.
REQ-009 in_data  in  NUM_INPUTS*WIDTH  lanes; lane k = bits [k*WIDTH +: WIDTH].
REQ-010 in_last  in  1  final beat of frame.
REQ-011 min_max  in  1  0 = min, 1 = max; sampled on first beat of frame.
REQ-012 tc  in  1  1 = two's-complement compare; sampled on first beat of frame.
REQ-013 out_valid  out  1  frame result valid.
REQ-014 out_ready  in  1  result consumed when out_valid & out_ready.
REQ-015 out_value  out  WIDTH  frame min or max.
REQ-016 out_index  out  IDX_W  beat_number*NUM_INPUTS + lane of winner.
REQ-017 out_ovf  out  1  frame exceeded MAX_BEATS.

Function
REQ-018 FSM states IDLE, ACC, DONE; IDLE->ACC on accepted beat without in_last; IDLE/ACC->DONE on accepted beat with in_last; DONE->IDLE on out_valid & out_ready.
REQ-019 in_ready = (state != DONE), combinational from state only; out_valid = (state == DONE).
REQ-020 Per-beat lane reduction combinational; accumulator register updated on every accepted beat.
REQ-021 Tie-break: lowest global index wins for both min and max (strict compare against accumulator, lowest lane within beat).
REQ-022 First beat of frame loads accumulator unconditionally from its lane winner; no sentinel value.
REQ-023 mode/tc latched on first beat; changes mid-frame ignored.
REQ-024 Latency: result visible (out_valid=1) the cycle after the in_last beat is accepted.
REQ-025 Beat counter saturates at MAX_BEATS-1; any accepted beat beyond MAX_BEATS sets sticky ovf, still compared, index uses saturated beat number.
REQ-026 out_value/out_index/out_ovf held stable while out_valid & !out_ready.
REQ-027 Single-beat frame (in_last on first beat) goes IDLE->DONE; index = lane.
REQ-028 NUM_INPUTS=1: lane index is zero-width-safe (contributes 0).

Reset
REQ-029 On nvdla_core_rstn low: state IDLE, out_valid 0, out_value 0, out_index 0, out_ovf 0, counter 0; in_ready 1.
REQ-030 Reset mid-frame or in DONE discards partial/pending result; no output after release until a new frame completes.

Configuration
REQ-031 Macro NV_MINMAX_TC_EN defined: tc honoured, signed compare when latched tc=1.
REQ-032 Macro NV_MINMAX_TC_EN undefined: tc ignored, unsigned compare only, signed-compare logic absent.

Structure
REQ-033 Package nv_minmax_pkg holds state enum, clog2-style IDX_W/lane-width functions.
REQ-034 Sub-module nv_minmax_lane_tree: combinational lane reduction returning winner value and lane index; instantiated once.

Verification (WIDTH=8, NUM_INPUTS=4, MAX_BEATS=4)
REQ-035 Max, unsigned, 2 beats {3,9,9,1},{2,9,0,0} last -> out_value 9, out_index 1, out_ovf 0.
REQ-036 Min, tc=1 (macro on), 1 beat {0x05,0xF0,0x80,0x7F} last -> out_value 0x80, out_index 2; macro off -> 0x05, index 0.
REQ-037 Backpressure: out_ready=0 for 5 cycles after result -> in_ready 0, outputs stable; out_ready=1 -> next cycle IDLE, in_ready 1.
REQ-038 5-beat max frame, winner 0xEE in lane 3 of beat 5 -> out_ovf 1, out_index 15, out_value 0xEE.
REQ-039 min_max toggled 0->1 mid-frame -> result still frame minimum.
REQ-040 Reset asserted in ACC after beat 1 -> out_valid 0; new 1-beat frame {7,7,7,7} last -> value 7, index 0.
